// File: rtl/note_tone_generator_if.sv
// Note-divider link between the melody sequencer (master) and the tone generator (slave).
// Carries the divider/volume/mute controls and the generated audio outputs.
interface note_tone_generator_if #(
    parameter int DIV_W = 20,
    parameter int VOL_W = 4
);
    logic [DIV_W-1:0]    note_div;
    logic [VOL_W-1:0]    vol;
    logic                mute;
    logic                audio_out;
    logic signed [15:0]  pcm_sample;
    logic                note_load;
    logic                playing;

    modport master (
        output note_div, vol, mute,
        input  audio_out, pcm_sample, note_load, playing
    );

    modport slave (
        input  note_div, vol, mute,
        output audio_out, pcm_sample, note_load, playing
    );
endinterface

// File: rtl/note_tone_generator.sv
// Square-wave tone generator: converts a full-period divider into a glitch-free buzzer
// drive and signed PCM sample, latching new dividers only at full-period boundaries.
module note_tone_generator #(
    parameter int DIV_W = 20,
    parameter int VOL_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    note_tone_generator_if.slave  bus
);
    typedef enum logic {IDLE, PLAY} state_t;

    state_t           state;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt;
    logic [VOL_W-1:0] vol_q;
    logic             phase;      // unmuted square-wave level; keeps running under mute

    logic [DIV_W-1:0] half_m1;
    logic             at_end;
    logic             wrap;
    logic             note_ok;
    logic             do_latch;
    logic             ph_next;

    function automatic logic signed [15:0] pcm_of(input logic ph, input logic m,
                                                  input logic [VOL_W-1:0] v);
        logic signed [15:0] amp;
        amp = {1'b0, v, {(15 - VOL_W){1'b0}}};
        if (m) return '0;
        return ph ? amp : -amp;
    endfunction

    assign half_m1  = {1'b0, div_q[DIV_W-1:1]} - DIV_W'(1);
    assign at_end   = (cnt == half_m1);
    // A low-phase end is the only point where a new divider may be taken.
    assign wrap     = (state == PLAY) && at_end && !phase;
    assign note_ok  = (bus.note_div >= DIV_W'(2));
    assign do_latch = note_ok && ((state == IDLE) || wrap);
    assign ph_next  = phase & ~at_end;

    // NOTE: all state and output registers use non-blocking assignments so every
    // branch sees the pre-edge values of cnt/phase/state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            div_q          <= '0;
            vol_q          <= '0;
            cnt            <= '0;
            phase          <= 1'b0;
            bus.audio_out  <= 1'b0;
            bus.pcm_sample <= '0;
            bus.note_load  <= 1'b0;
            bus.playing    <= 1'b0;
        end else if (do_latch) begin
            state          <= PLAY;
            div_q          <= bus.note_div;
            vol_q          <= bus.vol;
            cnt            <= '0;
            phase          <= 1'b1;
            bus.audio_out  <= ~bus.mute;
            bus.pcm_sample <= pcm_of(1'b1, bus.mute, bus.vol);
            bus.note_load  <= 1'b1;
            bus.playing    <= 1'b1;
        end else if ((state == IDLE) || wrap) begin
            state          <= IDLE;
            div_q          <= '0;
            cnt            <= '0;
            phase          <= 1'b0;
            bus.audio_out  <= 1'b0;
            bus.pcm_sample <= '0;
            bus.note_load  <= 1'b0;
            bus.playing    <= 1'b0;
        end else begin
            cnt            <= at_end ? '0 : cnt + DIV_W'(1);
            phase          <= ph_next;
            bus.audio_out  <= ph_next & ~bus.mute;
            bus.pcm_sample <= pcm_of(ph_next, bus.mute, vol_q);
            bus.note_load  <= 1'b0;
            bus.playing    <= 1'b1;
        end
    end
endmodule
